sprite_pixel_compositor: RTL
============================

// Module: sprite_pixel_compositor
// PURPOSE
//  Per-pixel sprite stage between the VGA pixel-coordinate stream and the video output mux.
//  Maps each incoming pixel (x,y) into the sprite box, fetches the 4-bit colour index from sprite ROM and looks it up in the 16-entry player palette.
//  Overlays the opaque result on the background RGB.
//  Steps a small animation-frame counter once per N video frames.
// PARAMETERS
//  SPR_W    64  sprite width in pixels
//  SPR_H    64  sprite height in pixels
//  N_ANIM   4   animation frames stored back-to-back in ROM
//  HOLD     8   video frames per animation frame (>=1)
//  X_W      10  pixel x coordinate width
//  Y_W      10  pixel y coordinate width
//  ADDR_W   $clog2(SPR_W*SPR_H*N_ANIM)  ROM address width (localparam)
// PORTS
//  i_clk          in   1       pixel clock
//  i_rst_n        in   1       asynchronous active-low reset
//  i_frame_start  in   1       one-cycle pulse at start of vertical blank
//  i_anim_en      in   1       1: animation advances; 0: frame index held
//  i_sprite_x     in   X_W     sprite top-left x; sampled only on i_frame_start
//  i_sprite_y     in   Y_W     sprite top-left y; sampled only on i_frame_start
//  i_flip_h       in   1       horizontal mirror; sampled only on i_frame_start
//  i_pix_valid    in   1       pixel coordinate qualifier
//  i_pix_x        in   X_W     current pixel x
//  i_pix_y        in   Y_W     current pixel y
//  i_bg_rgb       in   24      background colour for this pixel
//  o_rom_addr     out  ADDR_W  sprite ROM address (sync ROM, 1-cycle read latency)
//  i_rom_data     in   4       colour index returned one cycle after o_rom_addr
//  i_color_map    in   24x16   palette array; entry 0 is transparent
//  o_rgb          out  24      composited pixel colour
//  o_rgb_valid    out  1       o_rgb qualifier
//  o_hit          out  1       1 when o_rgb is an opaque sprite pixel
// BEHAVIOUR
//  Reset: all pipeline valids, o_rgb, o_rgb_valid, o_hit and o_rom_addr go to 0.
//    Latched position/flip go to 0; anim frame index and hold counter go to 0.
//  Shadow regs: i_sprite_x/y and i_flip_h are captured on the cycle i_frame_start=1.
//    A pixel presented on that same cycle still uses the old values.
//  Anim counter (advances on i_frame_start only):
//    - i_anim_en=0: hold count and frame index are both frozen.
//    - otherwise hold++; when hold reaches HOLD-1, hold->0 and frame++.
//    - frame wraps N_ANIM-1 -> 0.
//  S0 (cycle of i_pix_valid):
//    - Compute dx = pix_x - spr_x and dy = pix_y - spr_y, both modulo 2^X_W / 2^Y_W.
//    - in_box = (dx < SPR_W) && (dy < SPR_H); pixels left of or above the sprite wrap large and miss.
//    - col = flip ? SPR_W-1-dx : dx.
//    - o_rom_addr <= frame*SPR_W*SPR_H + dy*SPR_W + col, registered.
//    - When !in_box the address is don't-care but must remain in range.
//  S1: in_box, valid and bg_rgb are delayed one stage to align with i_rom_data.
//  S2 (registered outputs):
//    - o_hit = valid & in_box & (i_rom_data != 0).
//    - o_rgb = o_hit ? i_color_map[i_rom_data] : bg_rgb.
//    - o_rgb_valid = delayed valid.
//  Latency: exactly 2 cycles from i_pix_valid to o_rgb_valid; full throughput, no stalls.
//  i_pix_valid=0: bubble propagates; o_rgb_valid=0, o_hit=0, o_rgb holds its last value.
//  Sprite at right/bottom edge: out-of-screen part is never addressed; no special handling.
//  Index 15 (black) is opaque; only index 0 is transparent.
//  Async reset asserted mid-line: pipeline flushes immediately; the first valid output after release comes 2 cycles after the next i_pix_valid.
// STRUCTURE
//  sprite_pkg holds:
//    - typedef logic [23:0] rgb_t
//    - typedef rgb_t palette_t [0:15]
//    - localparam PIX_IDX_W=4, TRANSPARENT_IDX=0
//  Sub-module sprite_anim_ctr: hold/frame counters with wrap.
//    Ports: i_clk, i_rst_n, i_tick, i_en, o_frame.
//  Compositor top holds the shadow regs, S0 address math and the S1/S2 pipeline.
// TESTING
//  1 Reset then i_frame_start with sprite=(100,50); pixel (100,50), ROM idx 2 -> 2 cycles later o_rgb=palette[2], o_hit=1, o_rgb_valid=1.
//  2 Pixel (163,113) gives addr 4095; (164,50) and (99,50) -> o_rgb=i_bg_rgb, o_hit=0.
//  3 ROM idx 0 inside box -> o_rgb=bg, o_hit=0; idx 15 -> o_rgb=24'h000000, o_hit=1.
//  4 flip_h=1, pixel (100,50) -> o_rom_addr=63; sprite_x changed mid-frame -> no effect until next i_frame_start.
//  5 HOLD=2, N_ANIM=4, anim_en=1, 8 frame_starts -> frame sequence 0,1,1,2,2,3,3,0 and address offset frame*4096; anim_en=0 holds the frame.
//  6 i_rst_n dropped while valid pixels are in flight -> o_rgb_valid=0 immediately, no stale output after release.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite pixel compositor.
package sprite_pkg;

  typedef logic [23:0] rgb_t;
  typedef rgb_t palette_t [0:15];

  localparam int unsigned PIX_IDX_W = 4;
  localparam logic [PIX_IDX_W-1:0] TRANSPARENT_IDX = '0;

endpackage

// File: rtl/sprite_anim_ctr.sv
// Animation frame counter: steps the frame index once every HOLD enabled ticks, wrapping at N_ANIM.
module sprite_anim_ctr #(
  parameter int unsigned N_ANIM = 4,
  parameter int unsigned HOLD   = 8,
  localparam int unsigned FRAME_W = (N_ANIM > 1) ? $clog2(N_ANIM) : 1,
  localparam int unsigned HOLD_W  = (HOLD > 1) ? $clog2(HOLD) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_tick,
  input  logic               i_en,
  output logic [FRAME_W-1:0] o_frame
);

  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [FRAME_W-1:0] frame_q, frame_d;

  always_comb begin
    hold_d  = hold_q;
    frame_d = frame_q;
    if (i_tick && i_en) begin
      if (hold_q == HOLD_W'(HOLD - 1)) begin
        hold_d  = '0;
        frame_d = (frame_q == FRAME_W'(N_ANIM - 1)) ? '0 : frame_q + FRAME_W'(1);
      end else begin
        hold_d = hold_q + HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_q  <= '0;
      frame_q <= '0;
    end else begin
      hold_q  <= hold_d;
      frame_q <= frame_d;
    end
  end

  assign o_frame = frame_q;

endmodule

// File: rtl/sprite_pixel_compositor.sv
// Per-pixel sprite stage: maps (x,y) into the sprite box, reads the ROM colour index,
// looks it up in the palette and overlays opaque pixels on the background, 2-cycle latency.
module sprite_pixel_compositor
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W  = 64,
  parameter int unsigned SPR_H  = 64,
  parameter int unsigned N_ANIM = 4,
  parameter int unsigned HOLD   = 8,
  parameter int unsigned X_W    = 10,
  parameter int unsigned Y_W    = 10,
  localparam int unsigned ADDR_W  = $clog2(SPR_W * SPR_H * N_ANIM),
  localparam int unsigned FRAME_W = (N_ANIM > 1) ? $clog2(N_ANIM) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_frame_start,
  input  logic                 i_anim_en,
  input  logic [X_W-1:0]       i_sprite_x,
  input  logic [Y_W-1:0]       i_sprite_y,
  input  logic                 i_flip_h,
  input  logic                 i_pix_valid,
  input  logic [X_W-1:0]       i_pix_x,
  input  logic [Y_W-1:0]       i_pix_y,
  input  logic [23:0]          i_bg_rgb,
  output logic [ADDR_W-1:0]    o_rom_addr,
  input  logic [PIX_IDX_W-1:0] i_rom_data,
  input  palette_t             i_color_map,
  output logic [23:0]          o_rgb,
  output logic                 o_rgb_valid,
  output logic                 o_hit
);

  logic [X_W-1:0]     spr_x_q;
  logic [Y_W-1:0]     spr_y_q;
  logic               flip_q;
  logic [FRAME_W-1:0] frame;

  sprite_anim_ctr #(
    .N_ANIM (N_ANIM),
    .HOLD   (HOLD)
  ) u_anim_ctr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_tick  (i_frame_start),
    .i_en    (i_anim_en),
    .o_frame (frame)
  );

  // Shadow regs: pixels on the capture cycle still see the previous values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      spr_x_q <= '0;
      spr_y_q <= '0;
      flip_q  <= 1'b0;
    end else if (i_frame_start) begin
      spr_x_q <= i_sprite_x;
      spr_y_q <= i_sprite_y;
      flip_q  <= i_flip_h;
    end
  end

  // S0: address math
  logic [X_W-1:0]    dx, col;
  logic [Y_W-1:0]    dy;
  logic              in_box;
  logic [ADDR_W-1:0] base, addr_d;

  always_comb begin
    dx     = i_pix_x - spr_x_q;
    dy     = i_pix_y - spr_y_q;
    // Left/above pixels wrap to large unsigned offsets and fail the compare.
    in_box = (32'(dx) < SPR_W) && (32'(dy) < SPR_H);
    col    = flip_q ? (X_W'(SPR_W - 1) - dx) : dx;
    base   = ADDR_W'(frame) * ADDR_W'(SPR_W * SPR_H);
    // Out-of-box pixels park on the frame base so the address stays in range.
    addr_d = in_box ? (base + ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(col)) : base;
  end

  logic [ADDR_W-1:0] rom_addr_q;
  logic              valid_s1_q, in_box_s1_q;
  logic [23:0]       bg_s1_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rom_addr_q  <= '0;
      valid_s1_q  <= 1'b0;
      in_box_s1_q <= 1'b0;
      bg_s1_q     <= '0;
    end else begin
      rom_addr_q  <= addr_d;
      valid_s1_q  <= i_pix_valid;
      in_box_s1_q <= in_box;
      bg_s1_q     <= i_bg_rgb;
    end
  end

  // S2: palette lookup and overlay; o_rgb holds across bubbles.
  logic        hit_d, hit_q, rgb_valid_q;
  logic [23:0] rgb_d, rgb_q;

  always_comb begin
    hit_d = valid_s1_q & in_box_s1_q & (i_rom_data != TRANSPARENT_IDX);
    rgb_d = rgb_q;
    if (valid_s1_q) begin
      rgb_d = hit_d ? i_color_map[i_rom_data] : bg_s1_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hit_q       <= 1'b0;
      rgb_q       <= '0;
      rgb_valid_q <= 1'b0;
    end else begin
      hit_q       <= hit_d;
      rgb_q       <= rgb_d;
      rgb_valid_q <= valid_s1_q;
    end
  end

  assign o_rom_addr  = rom_addr_q;
  assign o_rgb       = rgb_q;
  assign o_rgb_valid = rgb_valid_q;
  assign o_hit       = hit_q;

endmodule
